// File: rtl/ram_arbiter.sv
// Two-port arbiter for the single-port program/data RAM: the CPU has priority, and a streak
// counter bounds how long the debug port can be starved.
module ram_arbiter #(
  parameter int unsigned ADDR_W        = 16,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned RD_LAT        = 2,
  parameter int unsigned MAX_CPU_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_lock,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_rden,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  localparam logic [1:0] LastCnt  = 2'(RD_LAT - 1);
  localparam logic [3:0] MaxBurst = 4'(MAX_CPU_BURST);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                owner_q, owner_d;  // 1 = debug port owns the current access
  logic [1:0]          cnt_q, cnt_d;
  logic [3:0]          streak_q, streak_d;
  logic                cpu_rvalid_q, cpu_rvalid_d;
  logic                dbg_rvalid_q, dbg_rvalid_d;
  logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0]   dbg_rdata_q, dbg_rdata_d;
  logic                cpu_win, dbg_win;

  always_comb begin
    cpu_win = cpu_req && !dbg_lock && !(dbg_req && (streak_q == MaxBurst));
    dbg_win = dbg_req && !cpu_win;
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    streak_d     = streak_q;
    cpu_rvalid_d = 1'b0;
    dbg_rvalid_d = 1'b0;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    unique case (state_q)
      StIdle: begin
        if (cpu_win) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          owner_d = 1'b0;
          state_d = StIssue;
        end else if (dbg_win) begin
          we_d    = dbg_we;
          addr_d  = dbg_addr;
          wdata_d = dbg_wdata;
          owner_d = 1'b1;
          state_d = StIssue;
        end
        if (!dbg_req || dbg_win) begin
          streak_d = '0;
        end else if (cpu_win && (streak_q != MaxBurst)) begin
          streak_d = streak_q + 4'd1;
        end
      end
      StIssue: begin
        if (we_q) begin
          state_d = StIdle;
        end else begin
          cnt_d   = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == LastCnt) begin
          state_d = StIdle;
          if (owner_q) begin
            dbg_rdata_d  = ram_q;
            dbg_rvalid_d = 1'b1;
          end else begin
            cpu_rdata_d  = ram_q;
            cpu_rvalid_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      streak_q     <= '0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      streak_q     <= streak_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dbg_rvalid_q <= dbg_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  // RAM port is driven only during the single issue cycle.
  always_comb begin
    ram_address = '0;
    ram_data    = '0;
    ram_rden    = 1'b0;
    ram_wren    = 1'b0;
    cpu_gnt     = 1'b0;
    dbg_gnt     = 1'b0;
    if (state_q == StIssue) begin
      ram_address = addr_q;
      ram_wren    = we_q;
      ram_rden    = !we_q;
      ram_data    = we_q ? wdata_q : '0;
      cpu_gnt     = !owner_q;
      dbg_gnt     = owner_q;
    end
    cpu_rvalid = cpu_rvalid_q;
    dbg_rvalid = dbg_rvalid_q;
    cpu_rdata  = cpu_rdata_q;
    dbg_rdata  = dbg_rdata_q;
    busy       = (state_q != StIdle);
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a two-stage registered-output RAM model (RD_LAT = 2).
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_lock;
  logic [15:0] dbg_addr;
  logic [7:0]  dbg_wdata, dbg_rdata;
  logic [15:0] ram_address;
  logic [7:0]  ram_data, ram_q;
  logic        ram_rden, ram_wren, busy;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  q1, q2;
  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = '0;
  logic [7:0]  poke_data = '0;
  logic [46:0] outs;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (ram_wren) mem[ram_address] <= ram_data;
    if (ram_rden) q1 <= mem[ram_address];
    q2 <= q1;
  end
  assign ram_q = q2;

  assign outs = {cpu_gnt, cpu_rvalid, cpu_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
                 ram_address, ram_data, ram_rden, ram_wren, busy};

  ram_arbiter #(.ADDR_W(16), .DATA_W(8), .RD_LAT(2), .MAX_CPU_BURST(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dbg_lock(dbg_lock),
    .ram_address(ram_address), .ram_data(ram_data), .ram_rden(ram_rden),
    .ram_wren(ram_wren), .ram_q(ram_q), .busy(busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    step();
    poke_en   = 1'b0;
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if (outs !== 47'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_cpu_read();
    poke(16'h1000, 8'hA9);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1000;
    step();  // T+1
    checks++;
    if ({cpu_gnt, dbg_gnt, ram_rden, ram_wren, busy, ram_address} !== {5'b10101, 16'h1000}) begin
      errors++;
      $display("FAIL rd_issue: got %b %b %b %b %b %h expected 1 0 1 0 1 1000",
               cpu_gnt, dbg_gnt, ram_rden, ram_wren, busy, ram_address);
    end
    cpu_req = 1'b0;
    step();  // T+2
    checks++;
    if ({busy, ram_rden, cpu_gnt, cpu_rvalid} !== 4'b1000) begin
      errors++;
      $display("FAIL rd_wait1: got %b%b%b%b expected 1000", busy, ram_rden, cpu_gnt, cpu_rvalid);
    end
    step();  // T+3
    checks++;
    if ({busy, cpu_rvalid} !== 2'b10) begin
      errors++;
      $display("FAIL rd_wait2: got %b%b expected 10", busy, cpu_rvalid);
    end
    step();  // T+4
    checks++;
    if ({cpu_rvalid, dbg_rvalid, busy, cpu_rdata} !== {3'b100, 8'hA9}) begin
      errors++;
      $display("FAIL rd_rvalid: got %b %b %b %h expected 1 0 0 a9",
               cpu_rvalid, dbg_rvalid, busy, cpu_rdata);
    end
    step();
    checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b0, 8'hA9}) begin
      errors++;
      $display("FAIL rd_hold: got %b %h expected 0 a9", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_dbg_write_cpu_read();
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0200; dbg_wdata = 8'h5C;
    step();
    checks++;
    if ({dbg_gnt, cpu_gnt, ram_wren, ram_rden, ram_address, ram_data}
        !== {4'b1010, 16'h0200, 8'h5C}) begin
      errors++;
      $display("FAIL wr_issue: got %b %b %b %b %h %h expected 1 0 1 0 0200 5c",
               dbg_gnt, cpu_gnt, ram_wren, ram_rden, ram_address, ram_data);
    end
    dbg_req = 1'b0;
    step();
    checks++;
    if ({dbg_gnt, ram_wren, busy} !== 3'b000) begin
      errors++;
      $display("FAIL wr_done: got %b%b%b expected 000", dbg_gnt, ram_wren, busy);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200;
    step();
    cpu_req = 1'b0;
    step();
    step();
    step();
    checks++;
    if ({cpu_rvalid, dbg_rvalid, cpu_rdata} !== {2'b10, 8'h5C}) begin
      errors++;
      $display("FAIL wr_readback: got %b %b %h expected 1 0 5c", cpu_rvalid, dbg_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] order = '0;
    int n = 0;
    int both = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'h11;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h0020; dbg_wdata = 8'h22;
    for (int i = 0; i < 40 && n < 10; i++) begin
      step();
      if ((cpu_gnt && dbg_gnt) || (ram_rden && ram_wren)) both++;
      if (cpu_gnt || dbg_gnt) begin
        order[n] = dbg_gnt;
        n++;
      end
      if (n == 10) begin
        cpu_req = 1'b0;
        dbg_req = 1'b0;
      end
    end
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    checks++;
    if (n != 10) begin
      errors++;
      $display("FAIL burst_count: got %0d grants expected 10", n);
    end
    checks++;
    if (order !== 10'b10_0001_0000) begin
      errors++;
      $display("FAIL burst_order: got %b expected 1000010000 (bit0 first, 1=dbg)", order);
    end
    checks++;
    if (both != 0) begin
      errors++;
      $display("FAIL burst_exclusive: got %0d overlapping cycles expected 0", both);
    end
    step();
    step();
  endtask

  task automatic test_lock();
    int viol = 0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0030; cpu_wdata = 8'h33;
    dbg_lock = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (cpu_gnt || busy) viol++;
    end
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL lock_hold: got %0d grant/busy cycles expected 0", viol);
    end
    dbg_lock = 1'b0;
    checks++;
    if (cpu_gnt !== 1'b0) begin
      errors++;
      $display("FAIL lock_release_first: got %b expected 0", cpu_gnt);
    end
    step();
    checks++;
    if (cpu_gnt !== 1'b1) begin
      errors++;
      $display("FAIL lock_release_gnt: got %b expected 1", cpu_gnt);
    end
    cpu_req = 1'b0;
    step();
  endtask

  task automatic test_reset_in_wait();
    int rv = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h1000;
    step();
    cpu_req = 1'b0;
    step();  // first WAIT cycle
    reset_n = 1'b0;
    #1;
    checks++;
    if (outs !== 47'd0) begin
      errors++;
      $display("FAIL rst_wait_outputs: got %h expected 0", outs);
    end
    step();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (cpu_rvalid || busy) rv++;
    end
    checks++;
    if (rv != 0) begin
      errors++;
      $display("FAIL rst_wait_no_rvalid: got %0d active cycles expected 0", rv);
    end
    cpu_req = 1'b1;
    step();
    cpu_req = 1'b0;
    step();
    step();
    step();
    checks++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b1, 8'hA9}) begin
      errors++;
      $display("FAIL rst_wait_recover: got %b %h expected 1 a9", cpu_rvalid, cpu_rdata);
    end
  endtask

  task automatic test_withdraw();
    int cg = 0;
    int acc = 0;
    int seen = 0;
    logic [7:0] got = '0;
    poke(16'h0300, 8'h77);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'h0300;
    step();
    checks++;
    if (dbg_gnt !== 1'b1) begin
      errors++;
      $display("FAIL wd_dbg_gnt: got %b expected 1", dbg_gnt);
    end
    dbg_req = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 8'h44;
    step();
    cpu_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (cpu_gnt) cg++;
      if (ram_rden || ram_wren) acc++;
      if (dbg_rvalid) begin
        seen++;
        got = dbg_rdata;
      end
    end
    checks++;
    if ({cg, acc} != {32'd0, 32'd0}) begin
      errors++;
      $display("FAIL wd_no_access: got gnt=%0d access=%0d expected 0 0", cg, acc);
    end
    checks++;
    if (seen != 1 || got !== 8'h77) begin
      errors++;
      $display("FAIL wd_dbg_read: got %0d pulses data %h expected 1 77", seen, got);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    dbg_lock = 1'b0;
    test_reset();
    test_cpu_read();
    test_dbg_write_cpu_read();
    test_back_to_back();
    test_lock();
    test_reset_in_wait();
    test_withdraw();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
